// File: rtl/alu_div.sv
// RV32M divide unit: DIV/DIVU/REM/REMU as a radix-2 restoring divider that
// produces one quotient bit per clock, with single-edge handling of the divide-by-zero and overflow cases.
module alu_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             flush,
   input  logic [5:0]       alucode,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   output logic             busy,
   output logic             result_valid,
   output logic [WIDTH-1:0] alu_result
);

   localparam logic [5:0] ALU_DIV  = 6'd20;
   localparam logic [5:0] ALU_DIVU = 6'd21;
   localparam logic [5:0] ALU_REM  = 6'd22;
   localparam logic [5:0] ALU_REMU = 6'd23;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_reg;
   logic [4:0]       cnt_reg;
   logic [WIDTH-1:0] dvd_reg;
   logic [WIDTH-1:0] dsr_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic             q_neg_reg;
   logic             r_neg_reg;
   logic             want_rem_reg;
   logic             valid_reg;
   logic [WIDTH-1:0] result_reg;

   logic             is_div_op;
   logic             is_signed;
   logic             is_rem;
   logic             div_by_zero;
   logic             overflow;
   logic [WIDTH-1:0] op1_abs;
   logic [WIDTH-1:0] op2_abs;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_diff;
   logic [WIDTH-1:0] quo_final;
   logic [WIDTH-1:0] rem_final;

   always_comb begin
      is_div_op   = (alucode == ALU_DIV) || (alucode == ALU_DIVU) ||
                    (alucode == ALU_REM) || (alucode == ALU_REMU);
      is_signed   = (alucode == ALU_DIV) || (alucode == ALU_REM);
      is_rem      = (alucode == ALU_REM) || (alucode == ALU_REMU);
      div_by_zero = (op2 == '0);
      overflow    = is_signed && (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == '1);
      // The most negative value negates to itself, which is its correct unsigned magnitude.
      op1_abs     = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
      op2_abs     = (is_signed && op2[WIDTH-1]) ? -op2 : op2;
      // 33-bit step so that divisors >= 2^31 still compare correctly.
      rem_shift   = {rem_reg, dvd_reg[WIDTH-1]};
      rem_diff    = rem_shift - {1'b0, dsr_reg};
      quo_final   = q_neg_reg ? -quo_reg : quo_reg;
      rem_final   = r_neg_reg ? -rem_reg : rem_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         dvd_reg      <= '0;
         dsr_reg      <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         q_neg_reg    <= 1'b0;
         r_neg_reg    <= 1'b0;
         want_rem_reg <= 1'b0;
         valid_reg    <= 1'b0;
         result_reg   <= '0;
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && !flush && is_div_op) begin
                  want_rem_reg <= is_rem;
                  cnt_reg      <= 5'd31;
                  if (div_by_zero) begin
                     quo_reg   <= '1;
                     rem_reg   <= op1;
                     q_neg_reg <= 1'b0;
                     r_neg_reg <= 1'b0;
                     state_reg <= DONE;
                  end else if (overflow) begin
                     quo_reg   <= {1'b1, {(WIDTH-1){1'b0}}};
                     rem_reg   <= '0;
                     q_neg_reg <= 1'b0;
                     r_neg_reg <= 1'b0;
                     state_reg <= DONE;
                  end else begin
                     dvd_reg   <= op1_abs;
                     dsr_reg   <= op2_abs;
                     rem_reg   <= '0;
                     quo_reg   <= '0;
                     q_neg_reg <= is_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                     r_neg_reg <= is_signed && op1[WIDTH-1];
                     state_reg <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state_reg <= IDLE;
               end else begin
                  // Negative difference means the divisor did not fit: keep the shifted value.
                  rem_reg <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                  quo_reg <= {quo_reg[WIDTH-2:0], ~rem_diff[WIDTH]};
                  dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
                  if (cnt_reg == 5'd0) state_reg <= DONE;
                  else                 cnt_reg   <= cnt_reg - 5'd1;
               end
            end
            DONE: begin
               if (flush) begin
                  state_reg <= IDLE;
               end else begin
                  result_reg <= want_rem_reg ? rem_final : quo_final;
                  valid_reg  <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy         = (state_reg != IDLE);
   assign result_valid = valid_reg;
   assign alu_result   = result_reg;

endmodule

// File: tb/tb_alu_div.sv
// Directed-vector bench for alu_div: hand-computed results, latency, busy
// window, start-while-busy, flush and mid-operation reset.
`timescale 1ns/1ps
module tb_alu_div;

   localparam logic [5:0] ALU_ADD  = 6'd0;
   localparam logic [5:0] ALU_DIV  = 6'd20;
   localparam logic [5:0] ALU_DIVU = 6'd21;
   localparam logic [5:0] ALU_REM  = 6'd22;
   localparam logic [5:0] ALU_REMU = 6'd23;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [5:0]  alucode;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        busy;
   logic        result_valid;
   logic [31:0] alu_result;

   int n_checks = 0;
   int n_pass   = 0;

   alu_div #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .flush        (flush),
      .alucode      (alucode),
      .op1          (op1),
      .op2          (op2),
      .busy         (busy),
      .result_valid (result_valid),
      .alu_result   (alu_result)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual === expected) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
   endtask

   // Called at a negedge with operands to present; start is held for one edge (E0).
   // Optionally pokes a second start at edge poke_at while the operation is running.
   task automatic issue_and_check(input string tag, input logic [5:0] code,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] exp, input int exp_lat, input int poke_at);
      int lat;
      int busy_cyc;
      bit got;
      alucode = code; op1 = a; op2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_cyc = 0; got = 1'b0;
      while (!got && lat < 80) begin
         if (result_valid) begin
            got = 1'b1;
         end else begin
            if (busy) busy_cyc++;
            if (lat == poke_at - 1) begin
               start = 1'b1; op1 = 32'd200; op2 = 32'd3;
            end else begin
               start = 1'b0;
            end
            lat++;
            @(negedge clk);
         end
      end
      start = 1'b0;
      check_value({tag, "/valid"}, 32'(got), 32'd1);
      check_value({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      check_value({tag, "/busy_cycles"}, 32'(busy_cyc), 32'(exp_lat));
      check_value({tag, "/busy_at_valid"}, 32'(busy), 32'd0);
      check_value({tag, "/result"}, alu_result, exp);
      $display("op %s: a=0x%08h b=0x%08h result=0x%08h latency=%0d", tag, a, b, alu_result, lat);
   endtask

   task automatic run_op(input string tag, input logic [5:0] code,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
      @(negedge clk);
      issue_and_check(tag, code, a, b, exp, exp_lat, 0);
   endtask

   task automatic count_valid(input string tag, input int cycles);
      int pulses;
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (result_valid) pulses++;
      end
      check_value({tag, "/no_valid"}, 32'(pulses), 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; alucode = ALU_ADD; op1 = '0; op2 = '0;
      repeat (3) @(negedge clk);
      check_value("reset/busy", 32'(busy), 32'd0);
      check_value("reset/valid", 32'(result_valid), 32'd0);
      check_value("reset/result", alu_result, 32'd0);
      rst = 1'b0;

      run_op("DIV 20/-3", ALU_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
      @(negedge clk);
      check_value("pulse/valid_drops", 32'(result_valid), 32'd0);
      check_value("pulse/result_held", alu_result, 32'hFFFF_FFFA);
      run_op("REM 20/-3", ALU_REM, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 33);
      run_op("DIVU big", ALU_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001, 33);
      run_op("REMU big", ALU_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33);
      run_op("DIV 5/0", ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("REMU 5/0", ALU_REMU, 32'd5, 32'd0, 32'h0000_0005, 1);
      run_op("DIV ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("REM ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("DIV min/2", ALU_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
      run_op("REM -7/2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("DIV -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);

      // Non-divide alucode must not start anything.
      @(negedge clk);
      alucode = ALU_ADD; op1 = 32'd9; op2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_value("bad_code/busy", 32'(busy), 32'd0);
      count_valid("bad_code", 3);

      // A second start at E5 is ignored; the first operation still returns 100/7.
      @(negedge clk);
      issue_and_check("DIVU 100/7 poke", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 5);

      // Flush at E10 of a DIVU with an ignored start at E5.
      @(negedge clk);
      alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      op1 = 32'd200; op2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_value("flush/busy_before", 32'(busy), 32'd1);
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_value("flush/busy_after", 32'(busy), 32'd0);
      count_valid("flush", 40);
      check_value("flush/result_held", alu_result, 32'd14);
      $display("op flush: DIVU 100/7 aborted at E10");

      // Flush and start together in IDLE: flush wins.
      @(negedge clk);
      alucode = ALU_DIVU; op1 = 32'd100; op2 = 32'd7; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check_value("flush_start/busy", 32'(busy), 32'd0);
      count_valid("flush_start", 3);

      // Fresh operation, then a back-to-back start in its valid cycle.
      run_op("DIVU 100/7", ALU_DIVU, 32'd100, 32'd7, 32'd14, 33);
      issue_and_check("REMU 100/7 b2b", ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0);

      // Reset at E15 of a REM operation.
      @(negedge clk);
      alucode = ALU_REM; op1 = 32'hFFFF_FFEC; op2 = 32'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_value("mid_reset/busy", 32'(busy), 32'd0);
      check_value("mid_reset/valid", 32'(result_valid), 32'd0);
      check_value("mid_reset/result", alu_result, 32'd0);
      count_valid("mid_reset", 40);
      $display("op reset: REM -20/3 discarded at E15");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
